// File: rtl/idct_1d_if.sv
// Vector handshake bundle for the 8-point inverse DCT: coefficient vector in,
// sample vector out, with the shared pipeline-advance enable.
interface idct_1d_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 12
);
   logic                  en;
   logic                  in_valid;
   logic [0:7][IN_W-1:0]  y;
   logic                  out_valid;
   logic [0:7][OUT_W-1:0] x;
   logic                  sat;

   modport master (output en, in_valid, y, input out_valid, x, sat);
   modport slave  (input en, in_valid, y, output out_valid, x, sat);
endinterface

// File: rtl/idct_1d.sv
// 8-point 1-D inverse DCT, jpeglib islow factorisation with 13-bit constants.
// Four en-gated stages: rotate/pre-add, butterflies/odd products, combine, descale+clip.
module idct_1d #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 12,
   parameter int FRAC  = 13
) (
   input  logic     clk_i,
   input  logic     rst_i,
   idct_1d_if.slave bus
);
   localparam int W = IN_W + 24;

   localparam logic signed [W-1:0] K_C6    = W'(4433);
   localparam logic signed [W-1:0] K_C6M   = W'(4433 - 15137);
   localparam logic signed [W-1:0] K_C6P   = W'(4433 + 6270);
   localparam logic signed [W-1:0] K_0298  = W'(2446);
   localparam logic signed [W-1:0] K_2053  = W'(16819);
   localparam logic signed [W-1:0] K_3072  = W'(25172);
   localparam logic signed [W-1:0] K_1501  = W'(12299);
   localparam logic signed [W-1:0] K_1175  = W'(9633);
   localparam logic signed [W-1:0] K_N0899 = W'(-7373);
   localparam logic signed [W-1:0] K_N2562 = W'(-20995);
   localparam logic signed [W-1:0] K_N1961 = W'(-16069);
   localparam logic signed [W-1:0] K_N0390 = W'(-3196);
   localparam logic signed [W-1:0] K_RND   = W'(2**(FRAC+2));
   localparam logic signed [W-1:0] K_MAX   = W'(2**(OUT_W-1) - 1);
   localparam logic signed [W-1:0] K_MIN   = W'(-(2**(OUT_W-1)));

   logic signed [W-1:0] w_yv [8];
   logic signed [W-1:0] w_e  [4];
   logic signed [W-1:0] w_o  [4];
   logic signed [W-1:0] w_z5m, w_m1, w_m2, w_m3, w_m4;
   logic signed [W-1:0] w_sh [8];
   logic [0:7][OUT_W-1:0] w_q;
   logic [7:0]            w_clip;

   logic [3:0]          r_vld;
   logic signed [W-1:0] r_y0s, r_y4s, r_rot2, r_rot3;
   logic signed [W-1:0] r_z1, r_z2, r_z3, r_z4, r_z5;
   logic signed [W-1:0] r_y1, r_y3, r_y5, r_y7;
   logic signed [W-1:0] r_e [4];
   logic signed [W-1:0] r_o [4];
   logic signed [W-1:0] r_s [8];
   logic [0:7][OUT_W-1:0] r_x;
   logic                  r_sat;

   for (genvar k = 0; k < 8; k++) begin : g_ext
      assign w_yv[k] = W'(signed'(bus.y[k]));
   end

   assign w_e[0] = r_y0s + r_y4s + r_rot3;
   assign w_e[1] = r_y0s - r_y4s + r_rot2;
   assign w_e[2] = r_y0s - r_y4s - r_rot2;
   assign w_e[3] = r_y0s + r_y4s - r_rot3;

   // z5 is shared into z3 and z4 before they feed the odd outputs
   assign w_z5m = r_z5 * K_1175;
   assign w_m1  = r_z1 * K_N0899;
   assign w_m2  = r_z2 * K_N2562;
   assign w_m3  = r_z3 * K_N1961 + w_z5m;
   assign w_m4  = r_z4 * K_N0390 + w_z5m;

   assign w_o[0] = r_y1 * K_1501 + w_m1 + w_m4;
   assign w_o[1] = r_y3 * K_3072 + w_m2 + w_m3;
   assign w_o[2] = r_y5 * K_2053 + w_m2 + w_m4;
   assign w_o[3] = r_y7 * K_0298 + w_m1 + w_m3;

   for (genvar n = 0; n < 8; n++) begin : g_out
      assign w_sh[n]   = r_s[n] >>> (FRAC + 3);
      assign w_clip[n] = (w_sh[n] > K_MAX) || (w_sh[n] < K_MIN);
      assign w_q[n]    = (w_sh[n] > K_MAX) ? K_MAX[OUT_W-1:0] :
                         (w_sh[n] < K_MIN) ? K_MIN[OUT_W-1:0] : w_sh[n][OUT_W-1:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_vld  <= '0;
         r_y0s  <= '0;
         r_y4s  <= '0;
         r_rot2 <= '0;
         r_rot3 <= '0;
         r_z1   <= '0;
         r_z2   <= '0;
         r_z3   <= '0;
         r_z4   <= '0;
         r_z5   <= '0;
         r_y1   <= '0;
         r_y3   <= '0;
         r_y5   <= '0;
         r_y7   <= '0;
         for (int n = 0; n < 4; n++) begin
            r_e[n] <= '0;
            r_o[n] <= '0;
         end
         for (int n = 0; n < 8; n++) r_s[n] <= '0;
         r_x    <= '0;
         r_sat  <= 1'b0;
      end else if (bus.en) begin
         r_vld  <= {r_vld[2:0], bus.in_valid};
         r_y0s  <= w_yv[0] <<< FRAC;
         r_y4s  <= w_yv[4] <<< FRAC;
         r_rot2 <= w_yv[2] * K_C6  + w_yv[6] * K_C6M;
         r_rot3 <= w_yv[2] * K_C6P + w_yv[6] * K_C6;
         r_z1   <= w_yv[7] + w_yv[1];
         r_z2   <= w_yv[5] + w_yv[3];
         r_z3   <= w_yv[7] + w_yv[3];
         r_z4   <= w_yv[5] + w_yv[1];
         r_z5   <= w_yv[7] + w_yv[3] + w_yv[5] + w_yv[1];
         r_y1   <= w_yv[1];
         r_y3   <= w_yv[3];
         r_y5   <= w_yv[5];
         r_y7   <= w_yv[7];
         for (int n = 0; n < 4; n++) begin
            r_e[n]     <= w_e[n];
            r_o[n]     <= w_o[n];
            r_s[n]     <= r_e[n] + r_o[n] + K_RND;
            r_s[7 - n] <= r_e[n] - r_o[n] + K_RND;
         end
         r_x    <= w_q;
         r_sat  <= r_vld[2] & (|w_clip);
      end
   end

   assign bus.out_valid = r_vld[3];
   assign bus.x         = r_x;
   assign bus.sat       = r_sat;
endmodule

// File: tb/tb_idct_1d.sv
// Directed-vector bench for idct_1d: table of coefficient vectors with
// hand-derived samples, plus en-gap streaming and mid-stream reset sequences.
module tb_idct_1d;
   typedef struct packed {
      logic [0:7][15:0] y;
      logic [0:7][11:0] x;
      logic             sat;
   } vec_t;

   typedef struct packed {
      logic [0:7][11:0] x;
      logic             sat;
      int               cap;
   } exp_t;

   localparam int NV = 18;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   idct_1d_if #(.IN_W(16), .OUT_W(12)) bus ();

   idct_1d #(.IN_W(16), .OUT_W(12), .FRAC(13)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   vec_t             tbl [NV];
   exp_t             q [$];
   int               nchk = 0;
   int               nerr = 0;
   int               ecnt = 0;
   int               n_out = 0;
   logic             exp_vld = 1'b0;
   logic [0:7][11:0] exp_x = '0;
   logic             exp_sat = 1'b0;

   function automatic vec_t mk(input int yi[8], input int xi[8], input logic s);
      vec_t v;
      for (int i = 0; i < 8; i++) begin
         v.y[i] = 16'(yi[i]);
         v.x[i] = 12'(xi[i]);
      end
      v.sat = s;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
      nchk++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   // one clock: drive, take the edge, then compare against the in-order model
   task automatic cyc(input logic e, input logic v, input logic [0:7][15:0] yy,
                      input logic [0:7][11:0] xe, input logic se);
      exp_t cur;
      bus.en       = e;
      bus.in_valid = v;
      bus.y        = yy;
      @(posedge clk_i);
      #1;
      if (e) begin
         ecnt++;
         while (q.size() > 0 && q[0].cap + 3 < ecnt) void'(q.pop_front());
         exp_vld = 1'b0;
         if (q.size() > 0 && q[0].cap + 3 == ecnt) begin
            cur     = q.pop_front();
            exp_vld = 1'b1;
            exp_x   = cur.x;
            exp_sat = cur.sat;
         end
         if (v) q.push_back('{x: xe, sat: se, cap: ecnt});
         if (bus.out_valid) n_out++;
      end
      chk("out_valid", 96'(bus.out_valid), 96'(exp_vld));
      if (exp_vld) begin
         chk("x", 96'(bus.x), 96'(exp_x));
         chk("sat", 96'(bus.sat), 96'(exp_sat));
      end else begin
         chk("sat_idle", 96'(bus.sat), 96'(1'b0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = mk('{8,0,0,0,0,0,0,0},      '{1,1,1,1,1,1,1,1}, 1'b0);
      tbl[1]  = mk('{-8,0,0,0,0,0,0,0},     '{-1,-1,-1,-1,-1,-1,-1,-1}, 1'b0);
      tbl[2]  = mk('{4,0,0,0,0,0,0,0},      '{1,1,1,1,1,1,1,1}, 1'b0);
      tbl[3]  = mk('{-4,0,0,0,0,0,0,0},     '{0,0,0,0,0,0,0,0}, 1'b0);
      tbl[4]  = mk('{0,1000,0,0,0,0,0,0},   '{173,147,98,34,-34,-98,-147,-173}, 1'b0);
      tbl[5]  = mk('{8,1000,0,0,0,0,0,0},   '{174,148,99,35,-33,-97,-146,-172}, 1'b0);
      tbl[6]  = mk('{0,0,1000,0,0,0,0,0},   '{163,68,-68,-163,-163,-68,68,163}, 1'b0);
      tbl[7]  = mk('{0,0,0,0,800,0,0,0},    '{100,-100,-100,100,100,-100,-100,100}, 1'b0);
      tbl[8]  = mk('{32767,0,0,0,0,0,0,0},  '{2047,2047,2047,2047,2047,2047,2047,2047}, 1'b1);
      tbl[9]  = mk('{-32768,0,0,0,0,0,0,0}, '{-2048,-2048,-2048,-2048,-2048,-2048,-2048,-2048}, 1'b1);
      tbl[10] = mk('{16376,0,0,0,0,0,0,0},  '{2047,2047,2047,2047,2047,2047,2047,2047}, 1'b0);
      tbl[11] = mk('{16380,0,0,0,0,0,0,0},  '{2047,2047,2047,2047,2047,2047,2047,2047}, 1'b1);
      tbl[12] = mk('{-16384,0,0,0,0,0,0,0}, '{-2048,-2048,-2048,-2048,-2048,-2048,-2048,-2048}, 1'b0);
      tbl[13] = mk('{0,0,0,1000,0,0,0,0},   '{147,-34,-173,-98,98,173,34,-147}, 1'b0);
      tbl[14] = mk('{0,0,0,0,0,1000,0,0},   '{98,-173,35,147,-147,-35,173,-98}, 1'b0);
      tbl[15] = mk('{0,0,0,0,0,0,1000,0},   '{68,-163,163,-68,-68,163,-163,68}, 1'b0);
      tbl[16] = mk('{0,0,0,0,0,0,0,1000},   '{34,-98,147,-173,173,-147,98,-34}, 1'b0);
      tbl[17] = mk('{16000,1000,0,0,0,0,0,0}, '{2047,2047,2047,2034,1966,1902,1853,1827}, 1'b1);

      bus.en       = 1'b0;
      bus.in_valid = 1'b0;
      bus.y        = '0;
      #12;
      chk("rst_out_valid", 96'(bus.out_valid), 96'(1'b0));
      chk("rst_x", 96'(bus.x), 96'(0));
      chk("rst_sat", 96'(bus.sat), 96'(1'b0));
      #10;
      rst_i = 1'b0;

      repeat (2) cyc(1'b1, 1'b0, '0, '0, 1'b0);

      for (int i = 0; i < NV; i++) cyc(1'b1, 1'b1, tbl[i].y, tbl[i].x, tbl[i].sat);
      repeat (5) cyc(1'b1, 1'b0, '0, '0, 1'b0);

      // en pattern 1,0,1,1,0; stalled cycles present a decoy vector that must be ignored
      n_out = 0;
      begin
         int j = 0;
         int k = 0;
         while (j < 8) begin
            if ((k % 5 != 1) && (k % 5 != 4)) begin
               cyc(1'b1, 1'b1, tbl[j].y, tbl[j].x, tbl[j].sat);
               j++;
            end else begin
               cyc(1'b0, 1'b1, tbl[8].y, '0, 1'b0);
            end
            k++;
         end
         for (int f = 0; f < 10; f++) begin
            cyc(((k % 5 != 1) && (k % 5 != 4)) ? 1'b1 : 1'b0, 1'b0, '0, '0, 1'b0);
            k++;
         end
      end
      chk("en_gap_out_count", 96'(n_out), 96'(8));

      cyc(1'b1, 1'b1, tbl[8].y, tbl[8].x, tbl[8].sat);
      cyc(1'b1, 1'b1, tbl[9].y, tbl[9].x, tbl[9].sat);
      cyc(1'b1, 1'b1, tbl[4].y, tbl[4].x, tbl[4].sat);
      cyc(1'b1, 1'b1, tbl[5].y, tbl[5].x, tbl[5].sat);
      #2;
      rst_i = 1'b1;
      #1;
      chk("midrst_out_valid", 96'(bus.out_valid), 96'(1'b0));
      chk("midrst_x", 96'(bus.x), 96'(0));
      chk("midrst_sat", 96'(bus.sat), 96'(1'b0));
      bus.in_valid = 1'b0;
      q.delete();
      exp_vld = 1'b0;
      exp_x   = '0;
      exp_sat = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (8) cyc(1'b1, 1'b0, '0, '0, 1'b0);
      cyc(1'b1, 1'b1, tbl[6].y, tbl[6].x, tbl[6].sat);
      repeat (4) cyc(1'b1, 1'b0, '0, '0, 1'b0);
      chk("drained", 96'(q.size()), 96'(0));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
